// File: rtl/alarm_bank_pkg.sv
// Shared definitions for the alarm bank: time layout, edit fields, keys, FSM states.
package alarm_bank_pkg;

  // Packed alarm time, MSB first: year, month, day, hour, minute, second
  localparam int unsigned TIME_W    = 52;
  localparam int unsigned YEAR_W    = 14;
  localparam int unsigned MONTH_W   = 6;
  localparam int unsigned FIELD_W   = 8;
  localparam int unsigned SEC_LSB   = 0;
  localparam int unsigned MIN_LSB   = 8;
  localparam int unsigned HOUR_LSB  = 16;
  localparam int unsigned DAY_LSB   = 24;
  localparam int unsigned MONTH_LSB = 32;
  localparam int unsigned YEAR_LSB  = 38;

  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [FIELD_W-1:0] day;
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] minute;
    logic [FIELD_W-1:0] sec;
  } alarm_time_t;

  localparam alarm_time_t TIME_RESET = '{year: 14'd2000, month: 6'd1, day: 8'd1,
                                         hour: 8'd0, minute: 8'd0, sec: 8'd0};

  // Cursor positions
  localparam logic [2:0] F_YEAR   = 3'd0;
  localparam logic [2:0] F_MONTH  = 3'd1;
  localparam logic [2:0] F_DAY    = 3'd2;
  localparam logic [2:0] F_HOUR   = 3'd3;
  localparam logic [2:0] F_MIN    = 3'd4;
  localparam logic [2:0] F_SEC    = 3'd5;
  localparam logic [2:0] F_ENABLE = 3'd6;
  localparam logic [2:0] F_SLOT   = 3'd7;

  // Key pulse patterns; anything else is ignored
  localparam logic [3:0] KEY_RIGHT = 4'b1000;
  localparam logic [3:0] KEY_LEFT  = 4'b0100;
  localparam logic [3:0] KEY_PLUS  = 4'b0010;
  localparam logic [3:0] KEY_MINUS = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } ring_state_e;

  // Gregorian leap-year rule
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    int unsigned y;
    y = 32'(year);
    return ((y % 4) == 0) && (((y % 100) != 0) || ((y % 400) == 0));
  endfunction

  // Number of days in the given month of the given year
  function automatic logic [FIELD_W-1:0] max_day(input logic [YEAR_W-1:0] year,
                                                 input logic [MONTH_W-1:0] month);
    logic [FIELD_W-1:0] d;
    case (month)
      6'd2:                     d = is_leap(year) ? 8'd29 : 8'd28;
      6'd4, 6'd6, 6'd9, 6'd11:  d = 8'd30;
      default:                  d = 8'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alarm_ring_fsm.sv
// Ring sequencer: IDLE / RINGING / SNOOZE with a shared seconds counter.
module alarm_ring_fsm
  import alarm_bank_pkg::*;
#(
  parameter int unsigned SLOT_W     = 2,
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic              key_plus,
  input  logic              key_minus,
  input  logic              match_any,
  input  logic [SLOT_W-1:0] match_slot,
  output logic              ring,
  output logic              snoozing,
  output logic [SLOT_W-1:0] ring_slot
);

  localparam int unsigned MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned CNT_W   = $clog2(MAX_SEC + 1);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  ring_state_e      state;
  logic [CNT_W-1:0] sec_cnt;

  // State, seconds counter and registered ring/snooze flags; keys take priority over ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ring      <= 1'b0;
      snoozing  <= 1'b0;
      ring_slot <= '0;
      sec_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick_1s && match_any) begin
            state     <= ST_RINGING;
            ring      <= 1'b1;
            ring_slot <= match_slot;
            sec_cnt   <= '0;
          end
        end
        ST_RINGING: begin
          if (key_plus) begin
            state    <= ST_SNOOZE;
            ring     <= 1'b0;
            snoozing <= 1'b1;
            sec_cnt  <= '0;
          end else if (key_minus) begin
            state   <= ST_IDLE;
            ring    <= 1'b0;
            sec_cnt <= '0;
          end else if (tick_1s) begin
            if (sec_cnt == RING_LAST) begin
              state   <= ST_IDLE;
              ring    <= 1'b0;
              sec_cnt <= '0;
            end else begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
          if (key_minus) begin
            state    <= ST_IDLE;
            snoozing <= 1'b0;
            sec_cnt  <= '0;
          end else if (tick_1s) begin
            if (sec_cnt == SNOOZE_LAST) begin
              state    <= ST_RINGING;
              ring     <= 1'b1;
              snoozing <= 1'b0;
              sec_cnt  <= '0;
            end else begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          ring     <= 1'b0;
          snoozing <= 1'b0;
          sec_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Bank of alarm slots with key-driven editing and a ring/snooze sequencer.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned SLOT_W     = $clog2(NUM_ALARMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1s,
  input  logic [3:0]        sw_in,
  input  logic [51:0]       cur_time,
  output logic [2:0]        cursor,
  output logic [SLOT_W-1:0] edit_slot,
  output logic [51:0]       edit_alarm,
  output logic              edit_en,
  output logic              blink,
  output logic              ring,
  output logic [SLOT_W-1:0] ring_slot
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_ALARMS - 1);

  alarm_time_t             slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   slot_en;
  logic                    snoozing;
  logic                    busy_c;
  logic                    key_right_c, key_left_c, key_plus_c, key_minus_c;
  logic                    edit_field_c, toggle_en_c, clear_en_c;
  alarm_time_t             cur_c, nxt_c;
  logic [FIELD_W-1:0]      day_lim_c, nxt_lim_c;
  logic                    match_any_c;
  logic [SLOT_W-1:0]       match_slot_c;

  // Key decode; plus/minus belong to the sequencer while it is active
  always_comb begin
    busy_c       = ring | snoozing;
    key_right_c  = (sw_in == KEY_RIGHT);
    key_left_c   = (sw_in == KEY_LEFT);
    key_plus_c   = (sw_in == KEY_PLUS);
    key_minus_c  = (sw_in == KEY_MINUS);
    edit_field_c = !busy_c && (key_plus_c || key_minus_c) && (cursor <= F_SEC);
    toggle_en_c  = !busy_c && (key_plus_c || key_minus_c) && (cursor == F_ENABLE);
    clear_en_c   = busy_c && key_minus_c;
  end

  // Cursor, slot selection and blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor    <= F_YEAR;
      edit_slot <= '0;
      blink     <= 1'b0;
    end else begin
      if (tick_1s) blink <= ~blink;
      if (key_right_c && cursor != F_SLOT) cursor <= cursor + 3'd1;
      if (key_left_c && cursor != F_YEAR)  cursor <= cursor - 3'd1;
      if (!busy_c && cursor == F_SLOT) begin
        if (key_plus_c)
          edit_slot <= (edit_slot == SLOT_LAST) ? '0 : edit_slot + SLOT_W'(1);
        else if (key_minus_c)
          edit_slot <= (edit_slot == '0) ? SLOT_LAST : edit_slot - SLOT_W'(1);
      end
    end
  end

  // Saturating field step of the edited slot, with day clamped to the month length
  always_comb begin
    cur_c     = slot_time[edit_slot];
    nxt_c     = cur_c;
    day_lim_c = max_day(cur_c.year, cur_c.month);
    if (key_plus_c) begin
      case (cursor)
        F_YEAR:  if (cur_c.year < 14'd9999)  nxt_c.year   = cur_c.year + 14'd1;
        F_MONTH: if (cur_c.month < 6'd12)    nxt_c.month  = cur_c.month + 6'd1;
        F_DAY:   if (cur_c.day < day_lim_c)  nxt_c.day    = cur_c.day + 8'd1;
        F_HOUR:  if (cur_c.hour < 8'd23)     nxt_c.hour   = cur_c.hour + 8'd1;
        F_MIN:   if (cur_c.minute < 8'd59)   nxt_c.minute = cur_c.minute + 8'd1;
        F_SEC:   if (cur_c.sec < 8'd59)      nxt_c.sec    = cur_c.sec + 8'd1;
        default: ;
      endcase
    end else if (key_minus_c) begin
      case (cursor)
        F_YEAR:  if (cur_c.year > 14'd1)     nxt_c.year   = cur_c.year - 14'd1;
        F_MONTH: if (cur_c.month > 6'd1)     nxt_c.month  = cur_c.month - 6'd1;
        F_DAY:   if (cur_c.day > 8'd1)       nxt_c.day    = cur_c.day - 8'd1;
        F_HOUR:  if (cur_c.hour > 8'd0)      nxt_c.hour   = cur_c.hour - 8'd1;
        F_MIN:   if (cur_c.minute > 8'd0)    nxt_c.minute = cur_c.minute - 8'd1;
        F_SEC:   if (cur_c.sec > 8'd0)       nxt_c.sec    = cur_c.sec - 8'd1;
        default: ;
      endcase
    end
    nxt_lim_c = max_day(nxt_c.year, nxt_c.month);
    if (nxt_c.day > nxt_lim_c) nxt_c.day = nxt_lim_c;
  end

  // Slot storage: field edits, enable toggles, and disable on ring dismissal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_ALARMS); i++) slot_time[i] <= TIME_RESET;
      slot_en <= '0;
    end else begin
      if (edit_field_c) slot_time[edit_slot] <= nxt_c;
      if (toggle_en_c)  slot_en[edit_slot]   <= ~slot_en[edit_slot];
      if (clear_en_c)   slot_en[ring_slot]   <= 1'b0;
    end
  end

  // Lowest-index enabled slot equal to the current time
  always_comb begin
    match_any_c  = 1'b0;
    match_slot_c = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (slot_en[i] && (slot_time[i] == alarm_time_t'(cur_time))) begin
        match_any_c  = 1'b1;
        match_slot_c = SLOT_W'(i);
      end
    end
  end

  // Registered view of the slot under edit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edit_alarm <= TIME_RESET;
      edit_en    <= 1'b0;
    end else begin
      edit_alarm <= slot_time[edit_slot];
      edit_en    <= slot_en[edit_slot];
    end
  end

  alarm_ring_fsm #(
    .SLOT_W    (SLOT_W),
    .RING_SEC  (RING_SEC),
    .SNOOZE_SEC(SNOOZE_SEC)
  ) u_ring_fsm (
    .clk       (clk),
    .rst       (rst),
    .tick_1s   (tick_1s),
    .key_plus  (key_plus_c),
    .key_minus (key_minus_c),
    .match_any (match_any_c),
    .match_slot(match_slot_c),
    .ring      (ring),
    .snoozing  (snoozing),
    .ring_slot (ring_slot)
  );

endmodule

// File: tb/tb_alarm_bank.sv
// Directed test of alarm_bank: editing, date clamping, ring/snooze/dismiss, reset.
`timescale 1ns/1ps
module tb_alarm_bank;

  localparam logic [3:0] K_RIGHT = 4'b1000;
  localparam logic [3:0] K_LEFT  = 4'b0100;
  localparam logic [3:0] K_PLUS  = 4'b0010;
  localparam logic [3:0] K_MINUS = 4'b0001;

  logic        clk;
  logic        rst;
  logic        tick_1s;
  logic [3:0]  sw_in;
  logic [51:0] cur_time;
  logic [2:0]  cursor;
  logic [1:0]  edit_slot;
  logic [51:0] edit_alarm;
  logic        edit_en;
  logic        blink;
  logic        ring;
  logic [1:0]  ring_slot;

  int checks = 0;
  int errors = 0;

  alarm_bank dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1s   (tick_1s),
    .sw_in     (sw_in),
    .cur_time  (cur_time),
    .cursor    (cursor),
    .edit_slot (edit_slot),
    .edit_alarm(edit_alarm),
    .edit_en   (edit_en),
    .blink     (blink),
    .ring      (ring),
    .ring_slot (ring_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {year[13:0], month[5:0], day, hour, min, sec}
  function automatic logic [51:0] mk(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {14'(y), 6'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    sw_in = k;
    step();
    sw_in = 4'b0000;
    step();
  endtask

  task automatic press_n(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
  endtask

  task automatic goto_field(input int c);
    press_n(K_LEFT, 7);
    press_n(K_RIGHT, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; tick_1s = 1'b0; sw_in = 4'b0000; cur_time = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_cursor", 64'(cursor), 64'd0);
    check("rst_edit_slot", 64'(edit_slot), 64'd0);
    check("rst_edit_alarm", 64'(edit_alarm), 64'(mk(2000, 1, 1, 0, 0, 0)));
    check("rst_edit_en", 64'(edit_en), 64'd0);
    check("rst_ring", 64'(ring), 64'd0);
    check("rst_ring_slot", 64'(ring_slot), 64'd0);
    check("rst_blink", 64'(blink), 64'd0);
    rst = 1'b1;
    step();

    // slot select wraps 0,1,2,3,0,1
    goto_field(7);
    check("cursor_sat_hi", 64'(cursor), 64'd7);
    press(K_RIGHT);
    check("cursor_sat_hi2", 64'(cursor), 64'd7);
    press(K_PLUS); check("slot_wrap_1", 64'(edit_slot), 64'd1);
    press(K_PLUS); check("slot_wrap_2", 64'(edit_slot), 64'd2);
    press(K_PLUS); check("slot_wrap_3", 64'(edit_slot), 64'd3);
    press(K_PLUS); check("slot_wrap_0", 64'(edit_slot), 64'd0);
    press(K_PLUS); check("slot_wrap_1b", 64'(edit_slot), 64'd1);
    press_n(K_PLUS, 3);
    check("slot_back_0", 64'(edit_slot), 64'd0);

    // slot 0: 2024-01-31, month+ clamps to Feb 29, year- clamps to Feb 28
    goto_field(0); press_n(K_PLUS, 24);
    goto_field(2); press_n(K_PLUS, 30);
    check("date_jan31", 64'(edit_alarm), 64'(mk(2024, 1, 31, 0, 0, 0)));
    goto_field(1); press(K_PLUS);
    check("date_feb29", 64'(edit_alarm), 64'(mk(2024, 2, 29, 0, 0, 0)));
    goto_field(0); press(K_MINUS);
    check("date_feb28", 64'(edit_alarm), 64'(mk(2023, 2, 28, 0, 0, 0)));
    goto_field(3); press(K_MINUS);
    check("hour_sat_lo", 64'(edit_alarm), 64'(mk(2023, 2, 28, 0, 0, 0)));
    press(4'b0011);
    check("bad_key_ignored", 64'(edit_alarm), 64'(mk(2023, 2, 28, 0, 0, 0)));
    press(4'b1100);
    check("bad_key_cursor", 64'(cursor), 64'd3);
    tick();
    check("blink_toggle", 64'(blink), 64'd1);

    // slot 2 at 2024-05-01 07:00:00, enabled, rings then auto-stops
    goto_field(7); press_n(K_PLUS, 2);
    goto_field(0); press_n(K_PLUS, 24);
    goto_field(1); press_n(K_PLUS, 4);
    goto_field(3); press_n(K_PLUS, 7);
    goto_field(6); press(K_PLUS);
    check("slot2_time", 64'(edit_alarm), 64'(mk(2024, 5, 1, 7, 0, 0)));
    check("slot2_en", 64'(edit_en), 64'd1);
    cur_time = mk(2024, 5, 1, 7, 0, 0);
    tick();
    check("ring_start", 64'(ring), 64'd1);
    check("ring_slot2", 64'(ring_slot), 64'd2);
    cur_time = '0;
    for (int i = 0; i < 29; i++) tick();
    check("ring_29", 64'(ring), 64'd1);
    tick();
    check("ring_auto_stop", 64'(ring), 64'd0);
    check("en_kept", 64'(edit_en), 64'd1);

    // slots 1 and 3 both at 2000-01-01 00:00:01 -> lowest index wins
    goto_field(7); press(K_MINUS);
    check("slot_dec_1", 64'(edit_slot), 64'd1);
    goto_field(5); press(K_PLUS);
    goto_field(6); press(K_PLUS);
    check("slot1_en", 64'(edit_en), 64'd1);
    goto_field(7); press_n(K_PLUS, 2);
    goto_field(5); press(K_PLUS);
    goto_field(6); press(K_PLUS);
    cur_time = mk(2000, 1, 1, 0, 0, 1);
    tick();
    check("dup_ring", 64'(ring), 64'd1);
    check("dup_ring_slot", 64'(ring_slot), 64'd1);
    cur_time = '0;
    press(K_MINUS);
    check("dismiss_ring", 64'(ring), 64'd0);
    check("minus_not_edit", 64'(edit_en), 64'd1);
    check("cursor_kept", 64'(cursor), 64'd6);
    goto_field(7); press_n(K_MINUS, 2);
    check("slot1_sel", 64'(edit_slot), 64'd1);
    check("slot1_disabled", 64'(edit_en), 64'd0);
    check("slot1_time", 64'(edit_alarm), 64'(mk(2000, 1, 1, 0, 0, 1)));

    // snooze: slot 2 rings, plus snoozes 300 s, re-rings, minus disables
    press(K_PLUS);
    check("slot2_sel", 64'(edit_slot), 64'd2);
    cur_time = mk(2024, 5, 1, 7, 0, 0);
    tick();
    check("ring2_again", 64'(ring), 64'd1);
    cur_time = mk(2000, 1, 1, 0, 0, 1);
    press(K_PLUS);
    check("snooze_ring_off", 64'(ring), 64'd0);
    check("snooze_plus_consumed", 64'(edit_slot), 64'd2);
    for (int i = 0; i < 299; i++) tick();
    check("snooze_299", 64'(ring), 64'd0);
    tick();
    check("snooze_rering", 64'(ring), 64'd1);
    check("snooze_slot", 64'(ring_slot), 64'd2);
    cur_time = '0;
    press(K_MINUS);
    check("snooze_dismiss", 64'(ring), 64'd0);
    check("slot2_disabled", 64'(edit_en), 64'd0);
    cur_time = mk(2024, 5, 1, 7, 0, 0);
    tick(); tick();
    check("no_rering", 64'(ring), 64'd0);

    // reset during snooze
    cur_time = mk(2000, 1, 1, 0, 0, 1);
    tick();
    check("ring3", 64'(ring_slot), 64'd3);
    cur_time = '0;
    press(K_PLUS);
    tick();
    rst = 1'b0;
    #2;
    check("arst_ring", 64'(ring), 64'd0);
    check("arst_ring_slot", 64'(ring_slot), 64'd0);
    check("arst_cursor", 64'(cursor), 64'd0);
    check("arst_edit_slot", 64'(edit_slot), 64'd0);
    check("arst_blink", 64'(blink), 64'd0);
    check("arst_edit_alarm", 64'(edit_alarm), 64'(mk(2000, 1, 1, 0, 0, 0)));
    step();
    rst = 1'b1;
    step();
    goto_field(7);
    for (int s = 1; s < 4; s++) begin
      press(K_PLUS);
      check("post_rst_en", 64'(edit_en), 64'd0);
      check("post_rst_time", 64'(edit_alarm), 64'(mk(2000, 1, 1, 0, 0, 0)));
    end
    cur_time = mk(2000, 1, 1, 0, 0, 1);
    tick();
    check("post_rst_no_ring", 64'(ring), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
